// File: rtl/regread_pkg.sv
// regread_pkg: shared constants for the register-read stage
// Provides one-hot opcode bit positions, the one-hot width and default datapath sizes.
package regread_pkg;
    localparam int OH_W        = 26;
    localparam int DEF_XLEN    = 16;
    localparam int DEF_NREGS   = 8;
    localparam int DEF_INSTR_W = 16;
    // Bit positions inside the decoded one-hot opcode vector.
    typedef enum int unsigned {
        ADA, ADC, ADZ, AWC, ACA, ACC, ACZ, ACW, ADI, NDU, NDC, NDZ, NCU,
        NCC, NCZ, LLI, LW, SW, LM, SM, BEQ, BLT, BLE, JAL, JLR, JRI
    } oh_idx_e;
endpackage

// File: rtl/regread_fwd_mux.sv
// regread_fwd_mux: one source operand's priority select
// Ports: idx (source index); ex/mem/wb valid, dest index and value; ex_is_load; gpr_val
// (register file read); val (resolved operand); load_hit (operand cannot be resolved yet).
// Macro REGREAD_FWD_EN: defined selects EX > MEM > WB > GPR forwarding; undefined keeps
// only the WB write-through and reports any pending EX/MEM writer as a hit.
module regread_fwd_mux #(
    parameter int XLEN  = 16,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [IDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]  ex_val,
    input  logic             mem_valid,
    input  logic [IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_val,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_val,
    input  logic [XLEN-1:0]  gpr_val,
    output logic [XLEN-1:0]  val,
    output logic             load_hit
);
    logic ex_hit, mem_hit, wb_hit;
    assign ex_hit  = ex_valid & (ex_rd == idx);
    assign mem_hit = mem_valid & (mem_rd == idx);
    assign wb_hit  = wb_valid & (wb_rd == idx);
`ifdef REGREAD_FWD_EN
    // A load in EX has no value yet: it is skipped as a source and flagged instead.
    assign load_hit = ex_hit & ex_is_load;
    assign val = (ex_hit & ~ex_is_load) ? ex_val :
                 mem_hit                ? mem_val :
                 wb_hit                 ? wb_val : gpr_val;
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_val, mem_val};
    assign load_hit = ex_hit | mem_hit;
    assign val      = wb_hit ? wb_val : gpr_val;
`endif
endmodule

// File: rtl/regread_fwd.sv
// regread_fwd: register-read stage with GPR file, operand forwarding and hazard control
// Inputs: decode slot (valid, pc, instr, one_hot, imm, rd/ra/rb indices, source-use flags),
// branch_valid_i flush, stall_i backpressure, EX/MEM/WB results (valid, value, dest, EX load flag).
// Outputs: hazard_stall_o (combinational hold of decode), registered execute payload and
// resolved operands. Macro REGREAD_FWD_EN enables the full forwarding network.
module regread_fwd
    import regread_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int NREGS   = DEF_NREGS,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               opcode_valid_i,
    input  logic [XLEN-1:0]    opcode_pc_i,
    input  logic [INSTR_W-1:0] opcode_instr_i,
    input  logic [OH_W-1:0]    one_hot_i,
    input  logic [XLEN-1:0]    imm_val_i,
    input  logic [IDX_W-1:0]   dec_rd_idx_i,
    input  logic [IDX_W-1:0]   dec_ra_idx_i,
    input  logic [IDX_W-1:0]   dec_rb_idx_i,
    input  logic               dec_uses_ra_i,
    input  logic               dec_uses_rb_i,
    input  logic               branch_valid_i,
    input  logic               stall_i,
    input  logic               ex_valid_i,
    input  logic               mem_valid_i,
    input  logic               wb_valid_i,
    input  logic [XLEN-1:0]    ex_val_i,
    input  logic [XLEN-1:0]    mem_val_i,
    input  logic [XLEN-1:0]    wb_val_i,
    input  logic [IDX_W-1:0]   ex_rd_idx_i,
    input  logic [IDX_W-1:0]   mem_rd_idx_i,
    input  logic [IDX_W-1:0]   wb_rd_idx_i,
    input  logic               ex_is_load_i,
    output logic               hazard_stall_o,
    output logic               opcode_valid_o,
    output logic [XLEN-1:0]    opcode_pc_o,
    output logic [INSTR_W-1:0] opcode_instr_o,
    output logic [OH_W-1:0]    one_hot_o,
    output logic [XLEN-1:0]    imm_val_o,
    output logic [XLEN-1:0]    operand_val_a,
    output logic [XLEN-1:0]    operand_val_b,
    output logic [IDX_W-1:0]   exec_rd_idx_o
);
    logic [XLEN-1:0] gpr [NREGS];
    logic [XLEN-1:0] val_a, val_b;
    logic            hit_a, hit_b, haz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
        end else if (wb_valid_i) begin
            gpr[wb_rd_idx_i] <= wb_val_i;
        end
    end

    regread_fwd_mux #(.XLEN(XLEN), .IDX_W(IDX_W)) u_mux_a (
        .idx(dec_ra_idx_i), .ex_valid(ex_valid_i), .ex_is_load(ex_is_load_i),
        .ex_rd(ex_rd_idx_i), .ex_val(ex_val_i), .mem_valid(mem_valid_i),
        .mem_rd(mem_rd_idx_i), .mem_val(mem_val_i), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_idx_i), .wb_val(wb_val_i), .gpr_val(gpr[dec_ra_idx_i]),
        .val(val_a), .load_hit(hit_a)
    );

    regread_fwd_mux #(.XLEN(XLEN), .IDX_W(IDX_W)) u_mux_b (
        .idx(dec_rb_idx_i), .ex_valid(ex_valid_i), .ex_is_load(ex_is_load_i),
        .ex_rd(ex_rd_idx_i), .ex_val(ex_val_i), .mem_valid(mem_valid_i),
        .mem_rd(mem_rd_idx_i), .mem_val(mem_val_i), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_idx_i), .wb_val(wb_val_i), .gpr_val(gpr[dec_rb_idx_i]),
        .val(val_b), .load_hit(hit_b)
    );

    assign haz            = opcode_valid_i & ((dec_uses_ra_i & hit_a) | (dec_uses_rb_i & hit_b));
    assign hazard_stall_o = haz | stall_i;

    // Payload loads on every non-stalled edge (a flush overrides the stall); flush and
    // hazard only kill the valid bit since the payload is then don't-care.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opcode_valid_o <= 1'b0;
            opcode_pc_o    <= '0;
            opcode_instr_o <= '0;
            one_hot_o      <= '0;
            imm_val_o      <= '0;
            operand_val_a  <= '0;
            operand_val_b  <= '0;
            exec_rd_idx_o  <= '0;
        end else if (branch_valid_i | ~stall_i) begin
            opcode_valid_o <= opcode_valid_i & ~branch_valid_i & ~haz;
            opcode_pc_o    <= opcode_pc_i;
            opcode_instr_o <= opcode_instr_i;
            one_hot_o      <= one_hot_i;
            imm_val_o      <= imm_val_i;
            operand_val_a  <= val_a;
            operand_val_b  <= val_b;
            exec_rd_idx_o  <= dec_rd_idx_i;
        end
    end
endmodule

// File: tb/tb_regread_fwd.sv
// tb_regread_fwd: randomized and directed check of regread_fwd against a behavioural model
module tb_regread_fwd;
    import regread_pkg::*;
    localparam int XLEN = DEF_XLEN, NREGS = DEF_NREGS, IDX_W = $clog2(DEF_NREGS);
    localparam int INSTR_W = DEF_INSTR_W;

    logic clk = 0, rst;
    logic opcode_valid_i, dec_uses_ra_i, dec_uses_rb_i, branch_valid_i, stall_i;
    logic ex_valid_i, mem_valid_i, wb_valid_i, ex_is_load_i;
    logic [XLEN-1:0] opcode_pc_i, imm_val_i, ex_val_i, mem_val_i, wb_val_i;
    logic [INSTR_W-1:0] opcode_instr_i;
    logic [OH_W-1:0] one_hot_i;
    logic [IDX_W-1:0] dec_rd_idx_i, dec_ra_idx_i, dec_rb_idx_i, ex_rd_idx_i, mem_rd_idx_i, wb_rd_idx_i;
    logic hazard_stall_o, opcode_valid_o;
    logic [XLEN-1:0] opcode_pc_o, imm_val_o, operand_val_a, operand_val_b;
    logic [INSTR_W-1:0] opcode_instr_o;
    logic [OH_W-1:0] one_hot_o;
    logic [IDX_W-1:0] exec_rd_idx_o;

    regread_fwd dut (
        .clk_i(clk), .rst_i(rst), .opcode_valid_i(opcode_valid_i), .opcode_pc_i(opcode_pc_i),
        .opcode_instr_i(opcode_instr_i), .one_hot_i(one_hot_i), .imm_val_i(imm_val_i),
        .dec_rd_idx_i(dec_rd_idx_i), .dec_ra_idx_i(dec_ra_idx_i), .dec_rb_idx_i(dec_rb_idx_i),
        .dec_uses_ra_i(dec_uses_ra_i), .dec_uses_rb_i(dec_uses_rb_i),
        .branch_valid_i(branch_valid_i), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .mem_valid_i(mem_valid_i), .wb_valid_i(wb_valid_i), .ex_val_i(ex_val_i),
        .mem_val_i(mem_val_i), .wb_val_i(wb_val_i), .ex_rd_idx_i(ex_rd_idx_i),
        .mem_rd_idx_i(mem_rd_idx_i), .wb_rd_idx_i(wb_rd_idx_i), .ex_is_load_i(ex_is_load_i),
        .hazard_stall_o(hazard_stall_o), .opcode_valid_o(opcode_valid_o),
        .opcode_pc_o(opcode_pc_o), .opcode_instr_o(opcode_instr_o), .one_hot_o(one_hot_o),
        .imm_val_o(imm_val_o), .operand_val_a(operand_val_a), .operand_val_b(operand_val_b),
        .exec_rd_idx_o(exec_rd_idx_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [XLEN-1:0] m_gpr [NREGS];
    logic e_valid, e_known;
    logic [XLEN-1:0] e_pc, e_imm, e_a, e_b;
    logic [INSTR_W-1:0] e_instr;
    logic [OH_W-1:0] e_oh;
    logic [IDX_W-1:0] e_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Value a source register would hold if every in-flight writer had already retired.
    function automatic logic [XLEN-1:0] resolve(input logic [IDX_W-1:0] r);
`ifdef REGREAD_FWD_EN
        if (ex_valid_i && !ex_is_load_i && ex_rd_idx_i == r) return ex_val_i;
        if (mem_valid_i && mem_rd_idx_i == r) return mem_val_i;
`endif
        if (wb_valid_i && wb_rd_idx_i == r) return wb_val_i;
        return m_gpr[r];
    endfunction

    function automatic logic blocked(input logic [IDX_W-1:0] r);
`ifdef REGREAD_FWD_EN
        return ex_valid_i && ex_is_load_i && ex_rd_idx_i == r;
`else
        return (ex_valid_i && ex_rd_idx_i == r) || (mem_valid_i && mem_rd_idx_i == r);
`endif
    endfunction

    task automatic step();
        logic haz;
        logic [XLEN-1:0] a, b;
        #1;
        haz = opcode_valid_i && ((dec_uses_ra_i && blocked(dec_ra_idx_i)) ||
                                 (dec_uses_rb_i && blocked(dec_rb_idx_i)));
        chk("hazard_stall", 32'(hazard_stall_o), 32'(haz || stall_i));
        a = resolve(dec_ra_idx_i);
        b = resolve(dec_rb_idx_i);
        if (rst) begin
            foreach (m_gpr[i]) m_gpr[i] = '0;
            {e_valid, e_pc, e_instr, e_oh, e_imm, e_a, e_b, e_rd} = '0;
            e_known = 1;
        end else begin
            if (wb_valid_i) m_gpr[wb_rd_idx_i] = wb_val_i;
            if (branch_valid_i || (!stall_i && haz)) begin
                e_valid = 0;
                e_known = 0;
            end else if (!stall_i) begin
                e_valid = opcode_valid_i; e_pc = opcode_pc_i; e_instr = opcode_instr_i;
                e_oh = one_hot_i; e_imm = imm_val_i; e_a = a; e_b = b; e_rd = dec_rd_idx_i;
                e_known = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_o", 32'(opcode_valid_o), 32'(e_valid));
        if (e_known) begin
            chk("pc_o", 32'(opcode_pc_o), 32'(e_pc));
            chk("instr_o", 32'(opcode_instr_o), 32'(e_instr));
            chk("one_hot_o", 32'(one_hot_o), 32'(e_oh));
            chk("imm_o", 32'(imm_val_o), 32'(e_imm));
            chk("operand_a", 32'(operand_val_a), 32'(e_a));
            chk("operand_b", 32'(operand_val_b), 32'(e_b));
            chk("rd_o", 32'(exec_rd_idx_o), 32'(e_rd));
        end
        @(negedge clk);
    endtask

    task automatic clr();
        {rst, opcode_valid_i, dec_uses_ra_i, dec_uses_rb_i, branch_valid_i, stall_i} = '0;
        {ex_valid_i, mem_valid_i, wb_valid_i, ex_is_load_i} = '0;
        {opcode_pc_i, imm_val_i, ex_val_i, mem_val_i, wb_val_i, opcode_instr_i, one_hot_i} = '0;
        {dec_rd_idx_i, dec_ra_idx_i, dec_rb_idx_i, ex_rd_idx_i, mem_rd_idx_i, wb_rd_idx_i} = '0;
    endtask

    task automatic issue(input int oh, input logic [XLEN-1:0] pc, input int rd, input int ra, input int rb);
        opcode_valid_i = 1; opcode_pc_i = pc; one_hot_i = OH_W'(1) << oh;
        opcode_instr_i = INSTR_W'($urandom); imm_val_i = XLEN'($urandom);
        dec_rd_idx_i = IDX_W'(rd); dec_ra_idx_i = IDX_W'(ra); dec_rb_idx_i = IDX_W'(rb);
        dec_uses_ra_i = 1; dec_uses_rb_i = 1;
    endtask

    initial begin
        clr();
        @(negedge clk);
        rst = 1; step();
        chk("rst_valid", 32'(opcode_valid_o), 32'(0));
        chk("rst_a", 32'(operand_val_a), 32'(0));
        clr();
        for (int i = 1; i < NREGS; i++) begin
            wb_valid_i = 1; wb_rd_idx_i = IDX_W'(i); wb_val_i = XLEN'(16'h1111 * (i + 1));
            step();
        end
        clr();
        issue(ADC, 16'h0102, 4, 5, 1);
        wb_valid_i = 1; wb_rd_idx_i = 5; wb_val_i = 16'h0014;
        step();
        chk("adc_a", 32'(operand_val_a), 32'h0014);
        chk("adc_b", 32'(operand_val_b), 32'h2222);
        clr();
        issue(ADZ, 16'h0104, 2, 5, 5); step();
        clr();
        issue(NDZ, 16'h0106, 1, 7, 3);
        ex_valid_i = 1; ex_rd_idx_i = 3; ex_val_i = 16'h00DC;
        mem_valid_i = 1; mem_rd_idx_i = 5; mem_val_i = 16'h00AB;
        wb_valid_i = 1; wb_rd_idx_i = 4; wb_val_i = 16'h00FF;
        step();
        clr();
        issue(ADC, 16'h0108, 1, 2, 3);
        ex_valid_i = 1; ex_rd_idx_i = 3; ex_val_i = 16'h00DC;
        mem_valid_i = 1; mem_rd_idx_i = 3; mem_val_i = 16'h00AB;
        wb_valid_i = 1; wb_rd_idx_i = 3; wb_val_i = 16'h00FF;
        step();
        ex_valid_i = 0; step();
        mem_valid_i = 0; step();
        clr();
        issue(ADI, 16'h010A, 2, 5, 0); dec_uses_rb_i = 0;
        ex_valid_i = 1; ex_is_load_i = 1; ex_rd_idx_i = 5; ex_val_i = 16'hDEAD;
        step();
        ex_valid_i = 0; ex_is_load_i = 0;
        mem_valid_i = 1; mem_rd_idx_i = 5; mem_val_i = 16'h0042;
        step();
        clr();
        issue(BEQ, 16'h0104, 0, 1, 2); branch_valid_i = 1; step();
        clr();
        issue(ADC, 16'h0110, 3, 1, 2); step();
        for (int i = 0; i < 3; i++) begin
            issue(NDZ, 16'h0200 + XLEN'(i), 4, 6, 6); stall_i = 1;
            wb_valid_i = 1; wb_rd_idx_i = 6; wb_val_i = 16'h0600 + XLEN'(i);
            step();
        end
        clr();
        issue(ADC, 16'h0120, 5, 6, 6); step();
        stall_i = 1; rst = 1; step();
        clr();
        issue(ADC, 16'h0130, 7, 6, 1); step();
        for (int n = 0; n < 500; n++) begin
            clr();
            rst = ($urandom_range(0, 59) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            branch_valid_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) != 0) issue(int'($urandom_range(0, OH_W - 1)), XLEN'($urandom),
                int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
                int'($urandom_range(0, NREGS - 1)));
            dec_uses_ra_i = 1'($urandom); dec_uses_rb_i = 1'($urandom);
            ex_valid_i = 1'($urandom); ex_is_load_i = ($urandom_range(0, 2) == 0);
            mem_valid_i = 1'($urandom); wb_valid_i = 1'($urandom);
            ex_rd_idx_i = IDX_W'($urandom); mem_rd_idx_i = IDX_W'($urandom); wb_rd_idx_i = IDX_W'($urandom);
            ex_val_i = XLEN'($urandom); mem_val_i = XLEN'($urandom); wb_val_i = XLEN'($urandom);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
